vend_sequencer: RTL and testbench

Front-end controller for the vending datapath. It accumulates inserted coins into an 8-bit credit register and turns a product selection into a single-cycle `buy` request to the purchase manager. It samples the one-hot grant/error reply, deducts the price on success, and pays out remaining credit as a coin-by-coin change stream. It sits between the coin/keypad front panel and the purchase manager, and is the only driver of the manager's `buy`, `product` and `credit` inputs.

---
 rtl/vend_sequencer.sv | 152 +++++++++++++++
 tb/tb_vend_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// Vending front-end: coin credit accumulation, buy handshake with the purchase manager, change payout.
// Optional AUTO_CHANGE_EN: pay out any remaining credit automatically after every purchase attempt.
module vend_sequencer #(
  parameter logic [7:0] PRICE_0 = 8'd75,
  parameter logic [7:0] PRICE_1 = 8'd20,
  parameter logic [7:0] PRICE_2 = 8'd30,
  parameter logic [7:0] PRICE_3 = 8'd40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       sel_valid,
  input  logic [1:0] sel_product,
  input  logic       coin_return,
  input  logic       change_ack,
  input  logic       apple,
  input  logic       banana,
  input  logic       carrot,
  input  logic       date,
  input  logic       error,
  output logic       buy,
  output logic [1:0] product,
  output logic [7:0] credit,
  output logic       busy,
  output logic       coin_reject,
  output logic       dispensed,
  output logic       denied,
  output logic       change_valid,
  output logic [1:0] change_coin
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CHANGE} state_t;

  state_t state;

  function automatic logic [7:0] coin_value(input logic [1:0] t);
    case (t)
      2'd0:    return 8'd5;
      2'd1:    return 8'd10;
      2'd2:    return 8'd25;
      default: return 8'd100;
    endcase
  endfunction

  function automatic logic [1:0] largest_coin(input logic [7:0] c);
    if (c >= 8'd25)      return 2'd2;
    else if (c >= 8'd10) return 2'd1;
    else                 return 2'd0;
  endfunction

  logic [8:0] coin_sum;
  logic [7:0] price;
  logic [4:0] reply;
  logic       grant_ok;
  logic [7:0] wait_credit;
  logic [7:0] paid_credit;

  always_comb begin
    coin_sum = {1'b0, credit} + {1'b0, coin_value(coin_type)};
    case (product)
      2'd0:    price = PRICE_0;
      2'd1:    price = PRICE_1;
      2'd2:    price = PRICE_2;
      default: price = PRICE_3;
    endcase
    // A grant counts only as a clean one-hot on the requested product's line.
    reply       = {error, date, carrot, banana, apple};
    grant_ok    = (reply == (5'b00001 << product));
    wait_credit = grant_ok ? (credit - price) : credit;
    paid_credit = credit - coin_value(change_coin);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      buy          <= 1'b0;
      product      <= 2'd0;
      credit       <= 8'd0;
      busy         <= 1'b0;
      coin_reject  <= 1'b0;
      dispensed    <= 1'b0;
      denied       <= 1'b0;
      change_valid <= 1'b0;
      change_coin  <= 2'd0;
    end else begin
      buy         <= 1'b0;
      coin_reject <= 1'b0;
      dispensed   <= 1'b0;
      denied      <= 1'b0;
      case (state)
        IDLE: begin
          if (coin_valid) begin
            if (coin_sum[8]) coin_reject <= 1'b1;
            else             credit      <= coin_sum[7:0];
          end else if (coin_return && credit != 8'd0) begin
            state        <= CHANGE;
            busy         <= 1'b1;
            change_valid <= 1'b1;
            change_coin  <= largest_coin(credit);
          end else if (sel_valid) begin
            product <= sel_product;
            state   <= REQ;
            buy     <= 1'b1;
            busy    <= 1'b1;
          end
        end
        REQ: begin
          coin_reject <= coin_valid;
          state       <= WAIT;
        end
        WAIT: begin
          coin_reject <= coin_valid;
          credit      <= wait_credit;
          dispensed   <= grant_ok;
          denied      <= !grant_ok;
`ifdef AUTO_CHANGE_EN
          if (wait_credit != 8'd0) begin
            state        <= CHANGE;
            change_valid <= 1'b1;
            change_coin  <= largest_coin(wait_credit);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        CHANGE: begin
          coin_reject <= coin_valid;
          if (change_ack) begin
            credit <= paid_credit;
            if (paid_credit == 8'd0) begin
              state        <= IDLE;
              busy         <= 1'b0;
              change_valid <= 1'b0;
            end else begin
              change_coin <= largest_coin(paid_credit);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer: verdicts and change coins are queued at stimulus time, popped by a monitor.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_product = 2'd0;
  logic       coin_return = 1'b0;
  logic       change_ack = 1'b1;
  logic       apple, banana, carrot, date, error;
  logic       buy;
  logic [1:0] product;
  logic [7:0] credit;
  logic       busy, coin_reject, dispensed, denied, change_valid;
  logic [1:0] change_coin;

  vend_sequencer dut (
    .clk(clk), .reset(reset),
    .coin_valid(coin_valid), .coin_type(coin_type),
    .sel_valid(sel_valid), .sel_product(sel_product),
    .coin_return(coin_return), .change_ack(change_ack),
    .apple(apple), .banana(banana), .carrot(carrot), .date(date), .error(error),
    .buy(buy), .product(product), .credit(credit), .busy(busy),
    .coin_reject(coin_reject), .dispensed(dispensed), .denied(denied),
    .change_valid(change_valid), .change_coin(change_coin)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int exp_credit = 0;
  int mgr_resp = 5;   // 0..3 grant that product, 4 error, 5 no reply
  int prices[4] = '{75, 20, 30, 40};
  int verdict_q[$];   // 2 = dispensed, 1 = denied
  int vcredit_q[$];
  int coin_q[$];

  // Purchase manager model: registers a reply to buy on the following edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      apple <= 1'b0; banana <= 1'b0; carrot <= 1'b0; date <= 1'b0; error <= 1'b0;
    end else begin
      apple  <= buy && mgr_resp == 0;
      banana <= buy && mgr_resp == 1;
      carrot <= buy && mgr_resp == 2;
      date   <= buy && mgr_resp == 3;
      error  <= buy && mgr_resp == 4;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int cval(input int t);
    case (t)
      0: return 5;
      1: return 10;
      2: return 25;
      default: return 100;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (dispensed || denied) begin
        if (verdict_q.size() == 0) check("verdict_unexpected", 1, 0);
        else begin
          check("verdict_kind", {dispensed, denied}, verdict_q.pop_front());
          check("verdict_credit", credit, vcredit_q.pop_front());
        end
      end
      if (change_valid && change_ack) begin
        if (coin_q.size() == 0) check("change_unexpected", 1, 0);
        else check("change_coin", change_coin, coin_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_change();
    int c = exp_credit;
    while (c > 0) begin
      if (c >= 25)      begin coin_q.push_back(2); c -= 25; end
      else if (c >= 10) begin coin_q.push_back(1); c -= 10; end
      else              begin coin_q.push_back(0); c -= 5;  end
    end
    exp_credit = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic insert(input int t);
    int tv = t;
    coin_valid = 1'b1;
    coin_type  = tv[1:0];
    tick();
    coin_valid = 1'b0;
    if (exp_credit + cval(t) <= 255) begin
      exp_credit += cval(t);
      check("coin_reject_low", coin_reject, 0);
    end else begin
      check("coin_reject_pulse", coin_reject, 1);
    end
    check("credit_after_coin", credit, exp_credit);
    $display("coin %0dc -> credit %0d reject %0d", cval(t), credit, coin_reject);
  endtask

  task automatic select(input int p, input int resp, input bit inject);
    int pv = p;
    bit ok = (resp == p);
    mgr_resp = resp;
    verdict_q.push_back(ok ? 2 : 1);
    if (ok) exp_credit -= prices[p];
    vcredit_q.push_back(exp_credit);
`ifdef AUTO_CHANGE_EN
    push_change();
`endif
    sel_valid   = 1'b1;
    sel_product = pv[1:0];
    tick();
    sel_valid = 1'b0;
    check("buy_pulse", buy, 1);
    check("busy_req", busy, 1);
    check("product", product, p);
    tick();
    check("buy_fall", buy, 0);
    if (inject) begin
      sel_valid  = 1'b1;
      coin_valid = 1'b1;
      coin_type  = 2'd0;
    end
    tick();
    if (inject) begin
      check("coin_reject_wait", coin_reject, 1);
      sel_valid  = 1'b0;
      coin_valid = 1'b0;
    end
    tick();
    check("no_second_buy", buy, 0);
    wait_idle();
    check("credit_after_vend", credit, exp_credit);
    $display("select %0d reply %0d -> %s credit %0d", p, resp, ok ? "dispense" : "deny", credit);
  endtask

  task automatic refund(input int hold);
    int first;
    int c0 = exp_credit;
    first = (c0 >= 25) ? 2 : (c0 >= 10) ? 1 : 0;
    push_change();
    change_ack  = (hold == 0);
    coin_return = 1'b1;
    tick();
    coin_return = 1'b0;
    check("change_valid_on", change_valid, 1);
    for (int i = 0; i < hold; i++) begin
      check("coin_stable", change_coin, first);
      check("credit_held", credit, c0);
      tick();
    end
    change_ack = 1'b1;
    wait_idle();
    check("credit_refunded", credit, 0);
    check("change_valid_off", change_valid, 0);
    $display("refund %0d -> credit %0d", c0, credit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick();
    check("rst_credit", credit, 0);
    check("rst_busy", busy, 0);
    check("rst_buy", buy, 0);
    check("rst_product", product, 0);
    check("rst_change_valid", change_valid, 0);
    tick();
    reset = 1'b1;
    tick();

    // Apple granted from 100c
    insert(3);
    select(0, 0, 1'b0);
    if (exp_credit > 0) refund(0);

    // Banana refused with error
    insert(1);
    insert(0);
    select(1, 4, 1'b0);
    if (exp_credit > 0) refund(0);

    // Overflow boundary
    insert(3); insert(3); insert(2); insert(2);
    insert(1);
    insert(0);
    check("credit_max", credit, 255);
    refund(0);

    // Credit 40, hopper stalls before accepting
    insert(2); insert(1); insert(0);
    refund(3);

    // Coin and selection together: coin wins
    coin_valid = 1'b1; coin_type = 2'd2;
    sel_valid  = 1'b1; sel_product = 2'd1;
    tick();
    coin_valid = 1'b0; sel_valid = 1'b0;
    exp_credit += 25;
    check("same_cycle_credit", credit, exp_credit);
    check("same_cycle_no_buy", buy, 0);
    check("same_cycle_idle", busy, 0);
    $display("coin+select -> credit %0d buy %0d", credit, buy);
    insert(1);
    select(2, 2, 1'b1);
    if (exp_credit > 0) refund(0);

    // Wrong grant, missing reply, then a good date purchase
    insert(2); insert(2);
    select(3, 0, 1'b0);
    if (exp_credit > 0) refund(0);
    insert(2); insert(2);
    select(3, 5, 1'b0);
    if (exp_credit > 0) refund(0);
    insert(2); insert(2);
    select(3, 3, 1'b0);
    if (exp_credit > 0) refund(0);

    // Asynchronous reset during change payout
    insert(2); insert(1);
    change_ack  = 1'b0;
    coin_return = 1'b1;
    tick();
    coin_return = 1'b0;
    check("pre_rst_change_valid", change_valid, 1);
    check("pre_rst_busy", busy, 1);
    tick();
    #2 reset = 1'b0;
    #1;
    check("async_rst_credit", credit, 0);
    check("async_rst_change_valid", change_valid, 0);
    check("async_rst_busy", busy, 0);
    $display("async reset mid-change -> credit %0d busy %0d", credit, busy);
    exp_credit = 0;
    tick();
    reset = 1'b1;
    change_ack = 1'b1;
    tick();
    insert(1);
    check("post_rst_busy", busy, 0);

    check("verdict_q_empty", verdict_q.size(), 0);
    check("coin_q_empty", coin_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
